// File: rtl/aes_req_arbiter.sv
// Two-requester front end for a fully pipelined AES-128 core: round-robin issue,
// bubble insertion and a {valid,id} tag pipe that returns each ciphertext to its owner.
module aes_req_arbiter #(
    parameter int LATENCY = 11,
    parameter int DW      = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_p,
    input  logic [DW-1:0] req0_k,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_p,
    input  logic [DW-1:0] req1_k,
    output logic          req1_ready,
    input  logic          hold,
    output logic [DW-1:0] aes_p,
    output logic [DW-1:0] aes_k,
    input  logic [DW-1:0] aes_c,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_c,
    output logic [3:0]    inflight,
    output logic          idle
);

    // One tag stage per cycle between the handshake and the core result appearing on C.
    localparam int STAGES = LATENCY + 1;

    logic                handshake;
    logic                grant_id;
    logic                prio_q, prio_d;
    logic [DW-1:0]       aes_p_q, aes_p_d;
    logic [DW-1:0]       aes_k_q, aes_k_d;
    logic [STAGES-1:0]   tag_valid_q, tag_valid_d;
    logic [STAGES-1:0]   tag_id_q, tag_id_d;
    logic [3:0]          inflight_q, inflight_d;

    // prio_q names the requester that wins when both are valid.
    always_comb begin
        handshake = !hold && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) begin
            grant_id = prio_q;
        end else begin
            grant_id = req1_valid;
        end
    end

    assign req0_ready = handshake && !grant_id;
    assign req1_ready = handshake && grant_id;

    always_comb begin
        prio_d  = prio_q;
        aes_p_d = '0;
        aes_k_d = '0;
        if (handshake) begin
            prio_d  = ~grant_id;
            aes_p_d = grant_id ? req1_p : req0_p;
            aes_k_d = grant_id ? req1_k : req0_k;
        end
        // The id bit is only set for real blocks so bubbles leave rsp_id at 0.
        tag_valid_d = {tag_valid_q[STAGES-2:0], handshake};
        tag_id_d    = {tag_id_q[STAGES-2:0], handshake & grant_id};
        inflight_d  = inflight_q + {3'b000, handshake} - {3'b000, tag_valid_q[STAGES-1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q      <= 1'b0;
            aes_p_q     <= '0;
            aes_k_q     <= '0;
            tag_valid_q <= '0;
            tag_id_q    <= '0;
            inflight_q  <= '0;
        end else begin
            prio_q      <= prio_d;
            aes_p_q     <= aes_p_d;
            aes_k_q     <= aes_k_d;
            tag_valid_q <= tag_valid_d;
            tag_id_q    <= tag_id_d;
            inflight_q  <= inflight_d;
        end
    end

    assign aes_p     = aes_p_q;
    assign aes_k     = aes_k_q;
    assign rsp_valid = tag_valid_q[STAGES-1];
    assign rsp_id    = tag_id_q[STAGES-1];
    assign rsp_c     = aes_c;
    assign inflight  = inflight_q;
    assign idle      = (inflight_q == 4'd0) && !handshake;

`ifndef SYNTHESIS
    a_one_ready: assert property (@(posedge clk) disable iff (rst)
        !(req0_ready && req1_ready));
    a_inflight_bound: assert property (@(posedge clk) disable iff (rst)
        inflight_q <= 4'(STAGES));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(inflight_q == 4'd0 && rsp_valid));
`endif

endmodule
